// File: rtl/serial_add_sub.sv
// serial_add_sub: bit-serial adder/subtractor, LSB first, one shared full-adder/full-difference cell.
module serial_add_sub #(
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             overflow,
    output logic             zero
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] work;
    logic [CW-1:0]    cnt;
    logic             mode_r;
    logic             c;
    logic             ai;
    logic             bi;
    logic             bit_out;
    logic             c_next;
    logic             last;
    logic [WIDTH-1:0] work_next;

    assign ready = state == IDLE;
    assign busy  = state == RUN;
    assign done  = state == DONE;

    // At the final step a_sh[0]/b_sh[0] hold the operand sign bits, so overflow needs no extra state.
    always_comb begin
        ai        = a_sh[0];
        bi        = b_sh[0];
        bit_out   = ai ^ bi ^ c;
        c_next    = mode_r ? ((~ai & bi) | (c & ~(ai ^ bi))) : ((ai & bi) | (c & (ai ^ bi)));
        work_next = {bit_out, work[WIDTH-1:1]};
        last      = cnt == CW'(WIDTH - 1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            a_sh     <= '0;
            b_sh     <= '0;
            work     <= '0;
            cnt      <= '0;
            mode_r   <= 1'b0;
            c        <= 1'b0;
            result   <= '0;
            carry    <= 1'b0;
            overflow <= 1'b0;
            zero     <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    a_sh   <= a;
                    b_sh   <= b;
                    mode_r <= mode;
                    c      <= 1'b0;
                    cnt    <= '0;
                    state  <= RUN;
                end
                RUN: begin
                    a_sh <= a_sh >> 1;
                    b_sh <= b_sh >> 1;
                    c    <= c_next;
                    work <= work_next;
                    cnt  <= cnt + 1'b1;
                    if (last) begin
                        state    <= DONE;
                        result   <= work_next;
                        carry    <= c_next;
                        overflow <= (mode_r ? (ai != bi) : (ai == bi)) && (bit_out != ai);
                        zero     <= work_next == '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_add_sub.sv
// tb_serial_add_sub: directed checks of the bit-serial adder/subtractor at WIDTH=6.
module tb_serial_add_sub;
    localparam int W = 6;

    typedef struct {
        logic         m;
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic [W-1:0] r;
        logic         c;
        logic         v;
        logic         z;
    } vec_t;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic         mode = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         ready;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         carry;
    logic         overflow;
    logic         zero;

    int errs = 0;
    int checks = 0;

    vec_t vecs [11] = '{
        '{1'b1, 6'd5,  6'd3,  6'd2,  1'b0, 1'b0, 1'b0},
        '{1'b1, 6'd3,  6'd5,  6'd62, 1'b1, 1'b0, 1'b0},
        '{1'b0, 6'd31, 6'd1,  6'd32, 1'b0, 1'b1, 1'b0},
        '{1'b1, 6'd32, 6'd1,  6'd31, 1'b0, 1'b1, 1'b0},
        '{1'b0, 6'd63, 6'd1,  6'd0,  1'b1, 1'b0, 1'b1},
        '{1'b1, 6'd42, 6'd42, 6'd0,  1'b0, 1'b0, 1'b1},
        '{1'b0, 6'd7,  6'd9,  6'd16, 1'b0, 1'b0, 1'b0},
        '{1'b0, 6'd20, 6'd10, 6'd30, 1'b0, 1'b0, 1'b0},
        '{1'b1, 6'd0,  6'd1,  6'd63, 1'b1, 1'b0, 1'b0},
        '{1'b0, 6'd40, 6'd40, 6'd16, 1'b1, 1'b1, 1'b0},
        '{1'b1, 6'd16, 6'd48, 6'd32, 1'b1, 1'b1, 1'b0}
    };

    serial_add_sub #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .mode(mode), .a(a), .b(b),
        .ready(ready), .busy(busy), .done(done), .result(result),
        .carry(carry), .overflow(overflow), .zero(zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic run_op(input string tag, input logic m, input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic [W-1:0] er, input logic ec, input logic ev, input logic ez,
                          input bit scr);
        int lat;
        int w;
        logic [W-1:0] hold;
        w = 0;
        while (!ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk({tag, " ready"}, 32'(ready), 32'd1);
        hold = result;
        start = 1'b1;
        mode = m;
        a = x;
        b = y;
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        chk({tag, " busy"}, 32'(busy), 32'd1);
        while (!done && lat < 20) begin
            if (scr) begin
                a = W'($urandom);
                b = W'($urandom);
                mode = ~mode;
                chk({tag, " hold"}, 32'(result), 32'(hold));
            end
            @(negedge clk);
            lat++;
        end
        chk({tag, " latency"}, lat, W);
        chk({tag, " result"}, 32'(result), 32'(er));
        chk({tag, " carry"}, 32'(carry), 32'(ec));
        chk({tag, " overflow"}, 32'(overflow), 32'(ev));
        chk({tag, " zero"}, 32'(zero), 32'(ez));
        @(negedge clk);
        chk({tag, " pulse"}, {30'd0, done, ready}, 32'b01);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int prev;
        int ndone;
        logic [W + 1:0] full;
        logic [W-1:0] r;
        logic ov;
        #3;
        chk("reset outs", {20'd0, ready, busy, done, carry, overflow, zero, result}, {20'd0, 6'b100000, 6'd0});
        @(negedge clk);
        reset = 1'b0;

        foreach (vecs[i])
            run_op($sformatf("vec%0d", i), vecs[i].m, vecs[i].x, vecs[i].y,
                   vecs[i].r, vecs[i].c, vecs[i].v, vecs[i].z, 1'b0);

        run_op("scramble", 1'b1, 6'd5, 6'd3, 6'd2, 1'b0, 1'b0, 1'b0, 1'b1);

        // Start held high: accept, 6 RUN cycles, DONE, IDLE -> one done every 8 cycles.
        start = 1'b1;
        mode = 1'b0;
        a = 6'd1;
        b = 6'd2;
        prev = -1;
        ndone = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) begin
                if (prev >= 0) chk("held period", i - prev, 8);
                prev = i;
                ndone++;
            end
        end
        start = 1'b0;
        chk("held dones", ndone, 5);
        chk("held result", 32'(result), 32'd3);

        run_op("pre-reset", 1'b0, 6'd20, 6'd10, 6'd30, 1'b0, 1'b0, 1'b0, 1'b0);
        start = 1'b1;
        mode = 1'b0;
        a = 6'd7;
        b = 6'd9;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid busy", 32'(busy), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("mid reset outs", {20'd0, ready, busy, done, carry, overflow, zero, result}, {20'd0, 6'b100000, 6'd0});
        @(negedge clk);
        reset = 1'b0;
        run_op("after reset", 1'b0, 6'd7, 6'd9, 6'd16, 1'b0, 1'b0, 1'b0, 1'b0);

        for (int x = 0; x < 64; x += 7)
            for (int y = 0; y < 64; y += 9)
                for (int m = 0; m < 2; m++) begin
                    full = (m == 1) ? ({2'b00, W'(x)} - {2'b00, W'(y)}) : ({2'b00, W'(x)} + {2'b00, W'(y)});
                    r = full[W-1:0];
                    ov = (m == 1) ? (W'(x) >> (W - 1)) != (W'(y) >> (W - 1)) : (W'(x) >> (W - 1)) == (W'(y) >> (W - 1));
                    ov = ov && (r[W-1] != W'(x) >> (W - 1));
                    run_op($sformatf("sweep m%0d %0d %0d", m, x, y), m[0], W'(x), W'(y),
                           r, full[W], ov, r == '0, 1'b0);
                end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
